// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard/forwarding controller.
package hazard_pkg;

   localparam int unsigned MAX_MEM_LAT     = 7;
   localparam int unsigned MAX_FLUSH_DEPTH = 3;

   typedef enum logic {
      FWD_NONE = 1'b0,
      FWD_EX   = 1'b1
   } fwd_sel_e;

   // Width of a scoreboard counter able to hold the value lat.
   function automatic int unsigned sb_w(input int unsigned lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller: decode fields in, stall/flush/forward out.
interface hazard_ctrl_if #(
   parameter int unsigned AW = 5
);
   logic          d_valid;
   logic [AW-1:0] d_rs1;
   logic [AW-1:0] d_rs2;
   logic          d_rs1_used;
   logic          d_rs2_used;
   logic [AW-1:0] d_rd;
   logic          d_reg_wr;
   logic          d_is_load;
   logic          br_taken;
   logic          stall_f;
   logic          stall_d;
   logic          flush_d;
   logic          fwd_a;
   logic          fwd_b;
   logic [31:0]   perf_stall_cnt;
   logic [31:0]   perf_flush_cnt;

   modport master (
      output d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used, d_rd, d_reg_wr, d_is_load, br_taken,
      input  stall_f, stall_d, flush_d, fwd_a, fwd_b, perf_stall_cnt, perf_flush_cnt
   );

   modport slave (
      input  d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used, d_rd, d_reg_wr, d_is_load, br_taken,
      output stall_f, stall_d, flush_d, fwd_a, fwd_b, perf_stall_cnt, perf_flush_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register load-latency scoreboard; a register is busy until its pending load data is visible.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NREG    = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [AW-1:0] i_load_rd,
   input  logic [AW-1:0] i_rs1,
   input  logic          i_rs1_used,
   input  logic [AW-1:0] i_rs2,
   input  logic          i_rs2_used,
   output logic          o_rs1_busy_c,
   output logic          o_rs2_busy_c
);

   localparam int unsigned CW = sb_w(MEM_LAT);

   logic [CW-1:0] r_cnt [NREG];

   // A new load reloads its counter (latest load wins); all others count down to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
      end else begin
         r_cnt[0] <= '0;
         for (int unsigned r = 1; r < NREG; r++) begin
            if (i_load && (i_load_rd == AW'(r))) begin
               r_cnt[r] <= CW'(MEM_LAT);
            end else if (r_cnt[r] != '0) begin
               r_cnt[r] <= r_cnt[r] - CW'(1);
            end
         end
      end
   end

   assign o_rs1_busy_c = i_rs1_used && (i_rs1 != '0) && (r_cnt[i_rs1] != '0);
   assign o_rs2_busy_c = i_rs2_used && (i_rs2 != '0) && (r_cnt[i_rs2] != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use stall, taken-branch flush and EX->ALU forwarding.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned NREG        = 32,
   parameter int unsigned AW          = 5,
   parameter int unsigned MEM_LAT     = 2,
   parameter int unsigned FLUSH_DEPTH = 1
) (
   input  logic        clk,
   input  logic        rst,
   hazard_ctrl_if.slave bus
);

   localparam int unsigned FW = 2;

   logic          r_ex_valid;
   logic          r_ex_reg_wr;
   logic          r_ex_is_load;
   logic [AW-1:0] r_ex_rd;
   logic [FW-1:0] r_flush_cnt;

   logic     w_rs1_busy;
   logic     w_rs2_busy;
   logic     w_honour;
   logic     w_flush;
   logic     w_stall;
   logic     w_issue;
   logic     w_sb_load;
   fwd_sel_e w_fwd_a;
   fwd_sel_e w_fwd_b;

   // A branch only counts when a real instruction sits in execute; flush overrides stall.
   assign w_honour  = r_ex_valid && bus.br_taken;
   assign w_flush   = !rst && (w_honour || (r_flush_cnt != '0));
   assign w_stall   = !rst && bus.d_valid && (w_rs1_busy || w_rs2_busy) && !w_flush;
   assign w_issue   = !rst && bus.d_valid && !w_stall && !w_flush;
   assign w_sb_load = w_issue && bus.d_is_load && bus.d_reg_wr && (bus.d_rd != '0);

   hazard_scoreboard #(
      .NREG    (NREG),
      .AW      (AW),
      .MEM_LAT (MEM_LAT)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_sb_load),
      .i_load_rd    (bus.d_rd),
      .i_rs1        (bus.d_rs1),
      .i_rs1_used   (bus.d_rs1_used),
      .i_rs2        (bus.d_rs2),
      .i_rs2_used   (bus.d_rs2_used),
      .o_rs1_busy_c (w_rs1_busy),
      .o_rs2_busy_c (w_rs2_busy)
   );

   // Execute shadow: mirrors what the ID/EX register receives (bubble when nothing issues).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid   <= 1'b0;
         r_ex_reg_wr  <= 1'b0;
         r_ex_is_load <= 1'b0;
         r_ex_rd      <= '0;
      end else begin
         r_ex_valid   <= w_issue;
         r_ex_reg_wr  <= w_issue && bus.d_reg_wr;
         r_ex_is_load <= w_issue && bus.d_is_load;
         r_ex_rd      <= w_issue ? bus.d_rd : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush_cnt <= '0;
      end else if (w_honour) begin
         r_flush_cnt <= FW'(FLUSH_DEPTH - 1);
      end else if (r_flush_cnt != '0) begin
         r_flush_cnt <= r_flush_cnt - FW'(1);
      end
   end

   // Loads are never forwarded from execute; the scoreboard stall covers them.
   assign w_fwd_a = (!rst && r_ex_valid && r_ex_reg_wr && !r_ex_is_load && bus.d_rs1_used &&
                     (r_ex_rd == bus.d_rs1) && (bus.d_rs1 != '0)) ? FWD_EX : FWD_NONE;
   assign w_fwd_b = (!rst && r_ex_valid && r_ex_reg_wr && !r_ex_is_load && bus.d_rs2_used &&
                     (r_ex_rd == bus.d_rs2) && (bus.d_rs2 != '0)) ? FWD_EX : FWD_NONE;

   assign bus.stall_f = w_stall;
   assign bus.stall_d = w_stall;
   assign bus.flush_d = w_flush;
   assign bus.fwd_a   = w_fwd_a;
   assign bus.fwd_b   = w_fwd_b;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_flush;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (w_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
         if (w_honour && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign bus.perf_stall_cnt = r_perf_stall;
   assign bus.perf_flush_cnt = r_perf_flush;
`else
   assign bus.perf_stall_cnt = '0;
   assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then random decode traffic vs a cycle-timeline model.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int unsigned NREG        = 32;
   localparam int unsigned AW          = 5;
   localparam int unsigned MEM_LAT     = 2;
   localparam int unsigned FLUSH_DEPTH = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.AW(AW)) bus ();

   hazard_ctrl #(
      .NREG        (NREG),
      .AW          (AW),
      .MEM_LAT     (MEM_LAT),
      .FLUSH_DEPTH (FLUSH_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: absolute cycle numbers at which each register becomes readable
   // and until which decode is squashed, plus the last issued instruction.
   int cyc;
   int ready_at [NREG];
   int flush_until;
   bit m_ex_valid, m_ex_wr, m_ex_ld;
   int m_ex_rd;
   int m_perf_stall, m_perf_flush;
   bit m_stall;
   logic obs_stall, obs_flush, obs_fwd_a, obs_fwd_b;

   function automatic bit m_busy(input int rs, input bit used);
      return used && (rs != 0) && (cyc < ready_at[rs]);
   endfunction

   task automatic m_reset();
      for (int r = 0; r < int'(NREG); r++) ready_at[r] = 0;
      flush_until  = -1;
      m_ex_valid   = 0;
      m_ex_wr      = 0;
      m_ex_ld      = 0;
      m_ex_rd      = 0;
      m_perf_stall = 0;
      m_perf_flush = 0;
   endtask

   // One decode cycle: apply inputs, compare outputs with the model, advance the model.
   task automatic drive(input bit dv, input int rd, input int rs1, input int rs2,
                        input bit u1, input bit u2, input bit wr, input bit ld,
                        input bit br, input bit r);
      bit honour, e_flush, e_stall, e_fa, e_fb, e_issue;
      @(negedge clk);
      rst            = r;
      bus.d_valid    = dv;
      bus.d_rd       = AW'(rd);
      bus.d_rs1      = AW'(rs1);
      bus.d_rs2      = AW'(rs2);
      bus.d_rs1_used = u1;
      bus.d_rs2_used = u2;
      bus.d_reg_wr   = wr;
      bus.d_is_load  = ld;
      bus.br_taken   = br;
      #1;
      honour  = !r && m_ex_valid && br;
      e_flush = !r && (honour || (cyc <= flush_until));
      e_stall = !r && dv && (m_busy(rs1, u1) || m_busy(rs2, u2)) && !e_flush;
      e_fa    = !r && m_ex_valid && m_ex_wr && !m_ex_ld && u1 && (m_ex_rd == rs1) && (rs1 != 0);
      e_fb    = !r && m_ex_valid && m_ex_wr && !m_ex_ld && u2 && (m_ex_rd == rs2) && (rs2 != 0);
      e_issue = !r && dv && !e_stall && !e_flush;
      obs_stall = bus.stall_d;
      obs_flush = bus.flush_d;
      obs_fwd_a = bus.fwd_a;
      obs_fwd_b = bus.fwd_b;
      check("stall_f", 32'(bus.stall_f), 32'(e_stall));
      check("stall_d", 32'(bus.stall_d), 32'(e_stall));
      check("flush_d", 32'(bus.flush_d), 32'(e_flush));
      check("fwd_a",   32'(bus.fwd_a),   32'(e_fa));
      check("fwd_b",   32'(bus.fwd_b),   32'(e_fb));
      m_stall = e_stall;
      if (r) begin
         m_reset();
      end else begin
         if (honour) begin
            flush_until = cyc + int'(FLUSH_DEPTH) - 1;
            m_perf_flush++;
         end
         if (e_stall) m_perf_stall++;
         if (e_issue && ld && wr && (rd != 0)) ready_at[rd] = cyc + int'(MEM_LAT) + 1;
         m_ex_valid = e_issue;
         m_ex_wr    = e_issue && wr;
         m_ex_ld    = e_issue && ld;
         m_ex_rd    = e_issue ? rd : 0;
      end
      cyc++;
   endtask

   task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_EN
      check({tag, "_perf_stall"}, bus.perf_stall_cnt, 32'(m_perf_stall));
      check({tag, "_perf_flush"}, bus.perf_flush_cnt, 32'(m_perf_flush));
`else
      check({tag, "_perf_stall"}, bus.perf_stall_cnt, 32'd0);
      check({tag, "_perf_flush"}, bus.perf_flush_cnt, 32'd0);
`endif
   endtask

   initial begin
      int n;
      bit hold, dv, u1, u2, wr, ld, br, r;
      int rd, rs1, rs2;
      cyc = 0;
      m_reset();

      // Reset with busy-looking inputs: every output must read 0.
      drive(1, 5, 5, 5, 1, 1, 1, 1, 1, 1);
      drive(1, 5, 5, 5, 1, 1, 1, 1, 1, 1);

      // Load-use: lw x5 then add x6,x5,x1 stalls exactly MEM_LAT cycles.
      drive(1, 5, 1, 0, 1, 0, 1, 1, 0, 0);
      n = 0;
      for (int k = 0; k < 10; k++) begin
         drive(1, 6, 5, 1, 1, 1, 1, 0, 0, 0);
         if (obs_stall) n++;
         else break;
      end
      check("t1_stall_len", 32'(n), 32'(MEM_LAT));
      check("t1_issue_fwd_a", 32'(obs_fwd_a), 32'd0);

      // ALU result forwarded to both operands.
      drive(1, 5, 0, 0, 1, 0, 1, 0, 0, 0);
      drive(1, 6, 5, 5, 1, 1, 1, 0, 0, 0);
      check("t2_fwd_a", 32'(obs_fwd_a), 32'd1);
      check("t2_fwd_b", 32'(obs_fwd_b), 32'd1);
      check("t2_stall", 32'(obs_stall), 32'd0);

      // x0 is never forwarded.
      drive(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      drive(1, 1, 0, 0, 1, 1, 1, 0, 0, 0);
      check("t3_fwd_a", 32'(obs_fwd_a), 32'd0);
      check("t3_fwd_b", 32'(obs_fwd_b), 32'd0);

      // Taken branch squashes a lw x7 for FLUSH_DEPTH cycles; x7 stays free.
      drive(1, 3, 1, 2, 1, 1, 0, 0, 0, 0);
      drive(1, 7, 1, 0, 1, 0, 1, 1, 1, 0);
      check("t4_flush0", 32'(obs_flush), 32'd1);
      drive(1, 7, 1, 0, 1, 0, 1, 1, 0, 0);
      check("t4_flush1", 32'(obs_flush), 32'd1);
      drive(1, 8, 7, 0, 1, 0, 1, 0, 0, 0);
      check("t4_flush_end", 32'(obs_flush), 32'd0);
      check("t4_x7_free", 32'(obs_stall), 32'd0);
      check_perf("t6");

      // Reset in the middle of a load-use stall leaves nothing behind.
      drive(1, 5, 1, 0, 1, 0, 1, 1, 0, 0);
      drive(1, 6, 5, 1, 1, 1, 1, 0, 0, 0);
      check("t5_stalled", 32'(obs_stall), 32'd1);
      drive(1, 6, 5, 1, 1, 1, 1, 0, 0, 1);
      drive(1, 6, 5, 1, 1, 1, 1, 0, 0, 0);
      check("t5_no_stall", 32'(obs_stall), 32'd0);
      check("t5_fwd_a", 32'(obs_fwd_a), 32'd0);

      // Random traffic over a small register window to provoke hazards; stalled decode holds.
      hold = 0;
      dv = 0; rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; wr = 0; ld = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!hold) begin
            dv  = ($urandom_range(0, 9) != 0);
            rd  = int'($urandom_range(0, 7));
            rs1 = int'($urandom_range(0, 7));
            rs2 = int'($urandom_range(0, 7));
            u1  = ($urandom_range(0, 4) != 0);
            u2  = ($urandom_range(0, 2) != 0);
            wr  = ($urandom_range(0, 4) != 0);
            ld  = ($urandom_range(0, 2) == 0);
         end
         br = ($urandom_range(0, 6) == 0);
         r  = ($urandom_range(0, 150) == 0);
         drive(dv, rd, rs1, rs2, u1, u2, wr, ld, br, r);
         hold = m_stall;
      end
      check_perf("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
